// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: on a load/store miss it freezes the pipeline,
// writes back a dirty victim line word by word, refills the requested line
// word by word, then strobes a tag update so the retried access hits.
module dcache_miss_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_access_M,
  input  logic [31:0] addr_M,
  input  logic        hit,
  input  logic        dirty,
  input  logic [31:0] victim_base,
  input  logic        mem_ack,
  output logic        stall_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        line_we,
  output logic [1:0]  line_word,
  output logic        tag_update,
  output logic [15:0] miss_count
);

  localparam int LINE_WORDS = 4;
  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WRITEBACK = 2'b01,
    REFILL    = 2'b10,
    UPDATE    = 2'b11
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  word_cnt_r, word_cnt_nxt_s;
  logic [27:0] addr_lat_r, addr_lat_nxt_s;
  logic [27:0] victim_lat_r, victim_lat_nxt_s;
  logic [15:0] miss_count_r, miss_count_nxt_s;

  // Registered copies of the memory-side outputs, decoded from next state
  logic        mem_req_r, mem_req_nxt_s;
  logic        mem_we_r, mem_we_nxt_s;
  logic [31:0] mem_addr_r, mem_addr_nxt_s;
  logic [1:0]  line_word_r, line_word_nxt_s;
  logic        tag_update_r, tag_update_nxt_s;

  // Byte-offset bits of the incoming addresses are never needed
  logic unused_s;
  assign unused_s = ^{addr_M[3:0], victim_base[3:0]};

  // Next-state, latch and counter logic for the miss sequence
  always_comb begin
    state_nxt_s      = state_r;
    word_cnt_nxt_s   = word_cnt_r;
    addr_lat_nxt_s   = addr_lat_r;
    victim_lat_nxt_s = victim_lat_r;
    miss_count_nxt_s = miss_count_r;
    case (state_r)
      IDLE: begin
        if (mem_access_M && !hit) begin
          addr_lat_nxt_s   = addr_M[31:4];
          victim_lat_nxt_s = victim_base[31:4];
          word_cnt_nxt_s   = 2'd0;
          if (miss_count_r != 16'hFFFF) begin
            miss_count_nxt_s = miss_count_r + 16'd1;
          end else begin
            miss_count_nxt_s = miss_count_r;
          end
          if (dirty) begin
            state_nxt_s = WRITEBACK;
          end else begin
            state_nxt_s = REFILL;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          word_cnt_nxt_s = word_cnt_r + 2'd1;
          if (word_cnt_r == LAST_WORD) begin
            state_nxt_s = REFILL;
          end else begin
            state_nxt_s = WRITEBACK;
          end
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          word_cnt_nxt_s = word_cnt_r + 2'd1;
          if (word_cnt_r == LAST_WORD) begin
            state_nxt_s = UPDATE;
          end else begin
            state_nxt_s = REFILL;
          end
        end else begin
          state_nxt_s = REFILL;
        end
      end
      UPDATE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Decode the memory-side outputs for the state being entered
  always_comb begin
    mem_req_nxt_s    = 1'b0;
    mem_we_nxt_s     = 1'b0;
    mem_addr_nxt_s   = 32'd0;
    line_word_nxt_s  = word_cnt_nxt_s;
    tag_update_nxt_s = 1'b0;
    case (state_nxt_s)
      WRITEBACK: begin
        mem_req_nxt_s  = 1'b1;
        mem_we_nxt_s   = 1'b1;
        mem_addr_nxt_s = {victim_lat_nxt_s, word_cnt_nxt_s, 2'b00};
      end
      REFILL: begin
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = {addr_lat_nxt_s, word_cnt_nxt_s, 2'b00};
      end
      UPDATE: begin
        tag_update_nxt_s = 1'b1;
      end
      default: begin
        mem_req_nxt_s = 1'b0;
      end
    endcase
  end

  // State, latched addresses, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      word_cnt_r   <= 2'd0;
      addr_lat_r   <= 28'd0;
      victim_lat_r <= 28'd0;
      miss_count_r <= 16'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      line_word_r  <= 2'd0;
      tag_update_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      word_cnt_r   <= word_cnt_nxt_s;
      addr_lat_r   <= addr_lat_nxt_s;
      victim_lat_r <= victim_lat_nxt_s;
      miss_count_r <= miss_count_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      line_word_r  <= line_word_nxt_s;
      tag_update_r <= tag_update_nxt_s;
    end
  end

  // Stall must rise in the miss cycle itself, and the data-array write
  // follows the acknowledge of the word currently being refilled
  always_comb begin
    if (state_r == IDLE) begin
      stall_cache = mem_access_M & ~hit;
    end else begin
      stall_cache = 1'b1;
    end
    if (state_r == REFILL) begin
      line_we = mem_ack;
    end else begin
      line_we = 1'b0;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign line_word  = line_word_r;
  assign tag_update = tag_update_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: a transaction-level model
// (words done so far, miss total) predicts every output each cycle,
// with directed scenarios adding hand-computed literal expectations.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_access_M;
  logic [31:0] addr_M;
  logic        hit;
  logic        dirty;
  logic [31:0] victim_base;
  logic        mem_ack;
  logic        stall_cache;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        line_we;
  logic [1:0]  line_word;
  logic        tag_update;
  logic [15:0] miss_count;

  int checks = 0;
  int passed = 0;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst), .mem_access_M(mem_access_M), .addr_M(addr_M),
    .hit(hit), .dirty(dirty), .victim_base(victim_base), .mem_ack(mem_ack),
    .stall_cache(stall_cache), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .line_we(line_we), .line_word(line_word),
    .tag_update(tag_update), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // A miss is a list of word transfers: 4 victim writes (if dirty) then
  // 4 refill reads; m_k counts transfers already acknowledged.
  bit          m_busy, m_upd, m_dirty;
  logic [27:0] m_a, m_v;
  int          m_k;
  int          m_misses;
  int          m_base = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_upd <= 1'b0; m_dirty <= 1'b0;
      m_a <= 28'd0; m_v <= 28'd0; m_k <= 0; m_misses <= 0;
    end else if (m_upd) begin
      m_upd <= 1'b0;
    end else if (m_busy) begin
      if (mem_ack) begin
        if (m_k == (m_dirty ? 7 : 3)) begin
          m_busy <= 1'b0;
          m_upd  <= 1'b1;
        end
        m_k <= m_k + 1;
      end
    end else if (mem_access_M && !hit) begin
      m_busy   <= 1'b1;
      m_dirty  <= dirty;
      m_a      <= addr_M[31:4];
      m_v      <= victim_base[31:4];
      m_k      <= 0;
      m_misses <= m_misses + 1;
    end
  end

  // Compare every DUT output with the model away from the active edge
  always @(negedge clk) begin
    int          tot;
    int          j;
    bit          wb;
    logic [27:0] ln;
    logic [31:0] e_addr;
    logic [15:0] e_cnt;
    if (!rst) begin
      tot   = m_base + m_misses;
      e_cnt = (tot > 65535) ? 16'hFFFF : tot[15:0];
      chk("miss_count", 32'(miss_count), 32'(e_cnt));
      if (m_upd) begin
        chk("upd_stall", 32'(stall_cache), 32'd1);
        chk("upd_req", 32'(mem_req), 32'd0);
        chk("upd_we", 32'(mem_we), 32'd0);
        chk("upd_line_we", 32'(line_we), 32'd0);
        chk("upd_tag", 32'(tag_update), 32'd1);
      end else if (m_busy) begin
        wb     = m_dirty && (m_k < 4);
        j      = m_k % 4;
        ln     = wb ? m_v : m_a;
        e_addr = {ln, j[1:0], 2'b00};
        chk("xfer_stall", 32'(stall_cache), 32'd1);
        chk("xfer_req", 32'(mem_req), 32'd1);
        chk("xfer_we", 32'(mem_we), 32'(wb));
        chk("xfer_addr", mem_addr, e_addr);
        chk("xfer_word", 32'(line_word), 32'(j[1:0]));
        chk("xfer_line_we", 32'(line_we), 32'(!wb && mem_ack));
        chk("xfer_tag", 32'(tag_update), 32'd0);
      end else begin
        chk("idle_stall", 32'(stall_cache), 32'(mem_access_M && !hit));
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_line_we", 32'(line_we), 32'd0);
        chk("idle_tag", 32'(tag_update), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra[4];
    logic [31:0] da[8];
    int st;
    int pulses;
    int n;
    ra = '{32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};
    da = '{32'h0000_8230, 32'h0000_8234, 32'h0000_8238, 32'h0000_823C,
           32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};

    rst = 1'b1; mem_access_M = 1'b0; addr_M = 32'd0; hit = 1'b0;
    dirty = 1'b0; victim_base = 32'd0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_tag", 32'(tag_update), 32'd0);
    chk("rst_count", 32'(miss_count), 32'd0);
    chk("rst_stall", 32'(stall_cache), 32'd0);
    rst = 1'b0;
    step();

    // Hits never stall or request memory
    mem_access_M = 1'b1; hit = 1'b1; mem_ack = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("hit_stall", 32'(stall_cache), 32'd0);
    chk("hit_count", 32'(miss_count), 32'd0);
    step();

    // Clean miss at 0x1234 with an ack every cycle
    hit = 1'b0; dirty = 1'b0; addr_M = 32'h0000_1234;
    st = 0;
    @(negedge clk); st += int'(stall_cache);
    step(); hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); st += int'(stall_cache);
      chk("clean_addr", mem_addr, ra[i]);
      chk("clean_line_we", 32'(line_we), 32'd1);
      step();
    end
    @(negedge clk); st += int'(stall_cache);
    chk("clean_tag", 32'(tag_update), 32'd1);
    step();
    @(negedge clk); st += int'(stall_cache);
    chk("clean_stall_cycles", 32'(st), 32'd6);
    chk("clean_count", 32'(miss_count), 32'd1);
    step();

    // Dirty miss; inputs scrambled after the miss edge must be ignored
    hit = 1'b0; dirty = 1'b1; addr_M = 32'h0000_1230; victim_base = 32'h0000_8230;
    @(negedge clk);
    step();
    hit = 1'b1; dirty = 1'b0; addr_M = 32'hDEAD_BEEF; victim_base = 32'hCAFE_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dirty_addr", mem_addr, da[i]);
      chk("dirty_we", 32'(mem_we), 32'(i < 4));
      step();
    end
    @(negedge clk);
    chk("dirty_tag", 32'(tag_update), 32'd1);
    step();

    // Refill with each ack arriving after three idle cycles
    hit = 1'b0; addr_M = 32'h0000_ABC8; mem_ack = 1'b0;
    @(negedge clk);
    step(); hit = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      mem_ack = ((i % 4) == 3);
      @(negedge clk); pulses += int'(line_we);
      step();
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("slow_tag", 32'(tag_update), 32'd1);
    chk("slow_pulses", 32'(pulses), 32'd4);
    step();

    // Reset after the second refill ack, then the miss restarts at word 0
    hit = 1'b0; addr_M = 32'h0000_5670; mem_ack = 1'b1;
    step(); hit = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_tag", 32'(tag_update), 32'd0);
    chk("rst_mid_line_we", 32'(line_we), 32'd0);
    @(negedge clk);
    rst = 1'b0; hit = 1'b0;
    step(); hit = 1'b1;
    @(negedge clk);
    chk("restart_addr", mem_addr, 32'h0000_5670);
    chk("restart_word", 32'(line_word), 32'd0);
    chk("restart_count", 32'(miss_count), 32'd1);
    mem_ack = 1'b1;
    repeat (6) step();

    // Randomized traffic; address/dirty inputs keep changing while busy
    for (int i = 0; i < 3000; i++) begin
      mem_access_M = 1'($urandom_range(0, 1));
      hit          = 1'($urandom_range(0, 1));
      dirty        = 1'($urandom_range(0, 1));
      addr_M       = $urandom;
      victim_base  = $urandom & 32'hFFFF_FFF0;
      mem_ack      = ($urandom_range(0, 2) != 0);
      step();
    end

    // Drain to idle, then preload the counter near saturation
    mem_access_M = 1'b0; mem_ack = 1'b1;
    n = 0;
    while ((m_busy || m_upd) && n < 50) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(m_busy || m_upd), 32'd0);
    @(negedge clk);
    #2;
    force dut.miss_count_r = 16'hFFFD;
    m_base = 65533 - m_misses;
    step();
    release dut.miss_count_r;
    for (int i = 0; i < 3; i++) begin
      mem_access_M = 1'b1; hit = 1'b0; dirty = 1'b0;
      step();
      hit = 1'b1;
      repeat (6) step();
    end
    @(negedge clk);
    chk("sat_count", 32'(miss_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
